// File: rtl/uart_tx_scheduler_if.sv
// FIFO read-port and UART launch handshake between the TX scheduler and its
// neighbours. The scheduler side uses the master modport; the FIFO and UART
// (or a testbench standing in for them) use the slave modport.
interface uart_tx_scheduler_if;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  tx_busy,
        output fifo_rd_en,
        output tx_start,
        output tx_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output tx_busy,
        input  fifo_rd_en,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: pops one byte at a time from the TX FIFO, hands it
// to the UART with a one-cycle start pulse, waits for the UART to finish, then
// optionally idles for a programmable gap before looking at the FIFO again.
// CTS and enable only gate the decision to fetch; once a byte has been popped
// it is always launched and completed.
module uart_tx_scheduler #(
    parameter int GAP_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [GAP_WIDTH-1:0] gap_cycles,
    input  logic                 cts_n,
    input  logic                 clr_count,
    uart_tx_scheduler_if.master  bus,
    output logic                 sched_active,
    output logic [CNT_WIDTH-1:0] bytes_sent
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        LAUNCH    = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_DONE = 3'd5,
        GAP       = 3'd6
    } state_t;

    localparam logic [GAP_WIDTH-1:0] GAP_ONE = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 byte_done;   // high on the WAIT_DONE exit cycle

    // State, latched byte and gap countdown registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state logic; the gap length is captured once on WAIT_DONE exit so
    // later changes to gap_cycles cannot disturb a running countdown
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        gap_d     = gap_q;
        byte_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !cts_n && !bus.fifo_empty && !bus.tx_busy) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                // FIFO read data is valid the cycle after the pop
                tx_data_d = bus.fifo_rd_data;
                state_d   = LAUNCH;
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    byte_done = 1'b1;
                    if (gap_cycles == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = gap_cycles;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - GAP_ONE;
                if (gap_q == GAP_ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating transmitted-byte counter; clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (byte_done && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Moore outputs decoded from the current state only
    assign bus.fifo_rd_en = (state_q == FETCH);
    assign bus.tx_start   = (state_q == LAUNCH);
    assign bus.tx_data    = tx_data_q;
    assign sched_active   = (state_q != IDLE);
    assign bytes_sent     = cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. A cycle-stepped model of the FIFO
// (registered read) and the UART (configurable start latency and busy time)
// drives the DUT; popped bytes go into a scoreboard queue and are compared
// against tx_data on every tx_start. bytes_sent is checked every cycle against
// a saturating reference count, and every gap is timed from the busy fall.
module tb_uart_tx_scheduler;
    localparam int GW      = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [GW-1:0] gap_cycles;
    logic          cts_n;
    logic          clr_count;
    logic          sched_active;
    logic [CW-1:0] bytes_sent;

    uart_tx_scheduler_if bus_if ();

    uart_tx_scheduler #(.GAP_WIDTH(GW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .gap_cycles   (gap_cycles),
        .cts_n        (cts_n),
        .clr_count    (clr_count),
        .bus          (bus_if),
        .sched_active (sched_active),
        .bytes_sent   (bytes_sent)
    );

    always #5 clk = ~clk;

    // bookkeeping
    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pops  = 0;
    int starts = 0;
    int outstanding = 0;

    // peripheral models
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int  uart_lat = 1;
    int  busy_len = 10;
    int  lat_cnt  = 0;
    int  busy_cnt = 0;
    bit  prev_rd_en = 0;
    bit  prev_start = 0;
    bit  prev_busy  = 0;
    bit  live       = 0;
    bit  fall_now   = 0;
    bit  gap_pend   = 0;
    int  fall_cyc   = 0;
    int  exp_gap    = 0;
    int  model_cnt  = 0;

    typedef struct {
        bit en;
        bit cts_n;
        int gap;
        int nbytes;
        int busy;
        int exp_starts;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    // Advance one clock; update the models for the edge just taken, then
    // sample and check the DUT outputs for the new cycle.
    task automatic step();
        bit in_reset;
        bit in_clr;
        bit was_fall;
        int in_gap;
        logic [7:0] e;
        in_reset = reset;
        in_clr   = clr_count;
        in_gap   = int'(gap_cycles);
        was_fall = fall_now;
        @(posedge clk);
        #1;
        cyc++;

        // FIFO with registered read data
        if (prev_rd_en) begin
            check("pop_nonempty", int'(fifo_q.size() > 0), 1);
            if (fifo_q.size() > 0) begin
                bus_if.fifo_rd_data = fifo_q.pop_front();
                exp_q.push_back(bus_if.fifo_rd_data);
            end
        end
        bus_if.fifo_empty = (fifo_q.size() == 0);

        // UART: busy rises uart_lat cycles after tx_start, lasts busy_len
        if (prev_start) lat_cnt = uart_lat;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_busy = bus_if.tx_busy;
        bus_if.tx_busy = (busy_cnt > 0);

        // reference state for the edge just taken
        if (in_reset) begin
            exp_q.delete();
            live        = 0;
            outstanding = 0;
            gap_pend    = 0;
            model_cnt   = 0;
        end else if (in_clr) begin
            model_cnt = 0;
        end else if (was_fall && model_cnt < CNT_MAX) begin
            model_cnt++;
        end
        if (was_fall && !in_reset) begin
            gap_pend = 1;
            fall_cyc = cyc - 1;
            exp_gap  = in_gap;
        end

        fall_now = live && prev_busy && !bus_if.tx_busy;
        if (fall_now) live = 0;

        // DUT checks
        check("bytes_sent", int'(bytes_sent), model_cnt);
        if (bus_if.fifo_rd_en) begin
            pops++;
            check("pop_before_launch", outstanding, 0);
            outstanding++;
        end
        if (bus_if.tx_start) begin
            starts++;
            check("launch_pops", outstanding, 1);
            outstanding = 0;
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_data", int'(bus_if.tx_data), int'(e));
            end
            live = 1;
            $display("[TB] cycle %0d launch tx_data=0x%02h bytes_sent=%0d",
                     cyc, bus_if.tx_data, bytes_sent);
        end
        if (gap_pend && !sched_active) begin
            check("gap_len", cyc - fall_cyc - 1, exp_gap);
            gap_pend = 0;
        end

        prev_rd_en = bus_if.fifo_rd_en;
        prev_start = bus_if.tx_start;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        bus_if.fifo_empty = 1'b0;
    endtask

    // Step until the scheduler and UART have been quiet for 8 cycles
    task automatic wait_quiet(input int bound);
        int q;
        q = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (!sched_active && !bus_if.tx_busy && lat_cnt == 0) q++;
            else q = 0;
            if (q >= 8) break;
        end
        check("settle", int'(q >= 8), 1);
    endtask

    task automatic flush_fifo();
        fifo_q.delete();
        bus_if.fifo_empty = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int p0;
        int got;
        int falls;

        vecs[0] = '{en: 1'b1, cts_n: 1'b0, gap: 0,   nbytes: 1, busy: 10, exp_starts: 1};
        vecs[1] = '{en: 1'b1, cts_n: 1'b0, gap: 3,   nbytes: 3, busy: 4,  exp_starts: 3};
        vecs[2] = '{en: 1'b0, cts_n: 1'b0, gap: 0,   nbytes: 2, busy: 4,  exp_starts: 0};
        vecs[3] = '{en: 1'b1, cts_n: 1'b1, gap: 0,   nbytes: 2, busy: 4,  exp_starts: 0};
        vecs[4] = '{en: 1'b1, cts_n: 1'b0, gap: 1,   nbytes: 2, busy: 1,  exp_starts: 2};
        vecs[5] = '{en: 1'b1, cts_n: 1'b0, gap: 255, nbytes: 2, busy: 2,  exp_starts: 2};
        vecs[6] = '{en: 1'b1, cts_n: 1'b0, gap: 0,   nbytes: 4, busy: 1,  exp_starts: 4};

        reset      = 1'b1;
        enable     = 1'b0;
        gap_cycles = '0;
        cts_n      = 1'b0;
        clr_count  = 1'b0;
        bus_if.fifo_empty   = 1'b1;
        bus_if.fifo_rd_data = 8'h00;
        bus_if.tx_busy      = 1'b0;

        // reset state
        repeat (3) step();
        reset = 1'b0;
        check("rst_rd_en",  int'(bus_if.fifo_rd_en), 0);
        check("rst_start",  int'(bus_if.tx_start), 0);
        check("rst_tx_data", int'(bus_if.tx_data), 0);
        check("rst_active", int'(sched_active), 0);
        check("rst_count",  int'(bytes_sent), 0);
        step();

        // single byte, exact latency
        busy_len = 10;
        push_byte(8'hA5);
        enable = 1'b1;
        step();
        check("lat_fetch",  int'(bus_if.fifo_rd_en), 1);
        check("lat_active", int'(sched_active), 1);
        step();
        check("lat_latch_rd", int'(bus_if.fifo_rd_en), 0);
        check("lat_latch_st", int'(bus_if.tx_start), 0);
        step();
        check("lat_launch", int'(bus_if.tx_start), 1);
        check("lat_data",   int'(bus_if.tx_data), 8'hA5);
        wait_quiet(200);
        check("single_count",  int'(bytes_sent), 1);
        check("single_active", int'(sched_active), 0);
        enable = 1'b0;

        // table-driven vectors
        for (int v = 0; v < 7; v++) begin
            enable     = vecs[v].en;
            cts_n      = vecs[v].cts_n;
            gap_cycles = GW'(vecs[v].gap);
            busy_len   = vecs[v].busy;
            s0 = starts;
            for (int i = 0; i < vecs[v].nbytes; i++) push_byte(8'($urandom_range(0, 255)));
            wait_quiet(4000);
            check($sformatf("vec%0d_starts", v), starts - s0, vecs[v].exp_starts);
            check($sformatf("vec%0d_left", v), fifo_q.size(), vecs[v].nbytes - vecs[v].exp_starts);
            enable = 1'b0;
            cts_n  = 1'b0;
            flush_fifo();
            step();
        end

        // gap_cycles changed during GAP does not disturb the countdown
        busy_len   = 3;
        gap_cycles = 8'd3;
        push_byte(8'h11);
        push_byte(8'h22);
        enable = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (fall_now) got = 1;
        end
        check("gapchg_fall", got, 1);
        step();
        gap_cycles = 8'd7;
        wait_quiet(300);
        check("gapchg_left", fifo_q.size(), 0);
        gap_cycles = '0;

        // flow control: CTS holds off fetch, and stops only the next fetch
        busy_len = 6;
        cts_n    = 1'b1;
        push_byte(8'h66);
        push_byte(8'h77);
        p0 = pops;
        repeat (50) step();
        check("cts_hold_pops", pops - p0, 0);
        s0 = starts;
        cts_n = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (bus_if.tx_start) got = 1;
        end
        check("cts_go_start", got, 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (bus_if.tx_busy) got = 1;
        end
        check("cts_busy_seen", got, 1);
        step();
        cts_n = 1'b1;
        wait_quiet(200);
        check("cts_mid_starts", starts - s0, 1);
        check("cts_mid_left", fifo_q.size(), 1);
        cts_n = 1'b0;
        wait_quiet(200);
        check("cts_drain_left", fifo_q.size(), 0);

        // enable dropped in LATCH: popped byte still goes out
        busy_len = 4;
        push_byte(8'h88);
        push_byte(8'h99);
        s0 = starts;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (bus_if.fifo_rd_en) got = 1;
        end
        check("en_fetch_seen", got, 1);
        step();
        enable = 1'b0;
        step();
        check("en_launch", int'(bus_if.tx_start), 1);
        check("en_data", int'(bus_if.tx_data), 8'h88);
        wait_quiet(200);
        check("en_starts", starts - s0, 1);
        check("en_left", fifo_q.size(), 1);
        enable = 1'b1;
        wait_quiet(200);
        check("en_drain_left", fifo_q.size(), 0);

        // counter saturation and clear-wins-over-increment
        busy_len  = 1;
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check("clr_idle", int'(bytes_sent), 0);
        for (int i = 0; i < 17; i++) push_byte(8'(i * 13 + 5));
        wait_quiet(2000);
        check("sat_count", int'(bytes_sent), CNT_MAX);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check("clr_sat", int'(bytes_sent), 0);
        for (int i = 0; i < 3; i++) push_byte(8'(i + 8'hE0));
        falls = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            if (fall_now) begin
                falls++;
                if (falls == 3) begin
                    clr_count = 1'b1;
                    step();
                    clr_count = 1'b0;
                    got = 1;
                end
            end
        end
        check("clr_exit_seen", got, 1);
        check("clr_exit_count", int'(bytes_sent), 0);
        wait_quiet(200);

        // reset during WAIT_BUSY: popped byte abandoned, next byte fetched
        uart_lat = 4;
        busy_len = 5;
        push_byte(8'hC1);
        push_byte(8'hC2);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (bus_if.tx_start) got = 1;
        end
        check("rstmid_launch", got, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_rd_en",  int'(bus_if.fifo_rd_en), 0);
        check("rstmid_start",  int'(bus_if.tx_start), 0);
        check("rstmid_data",   int'(bus_if.tx_data), 0);
        check("rstmid_count",  int'(bytes_sent), 0);
        check("rstmid_active", int'(sched_active), 0);
        s0 = starts;
        wait_quiet(300);
        check("rstmid_starts", starts - s0, 1);
        check("rstmid_left", fifo_q.size(), 0);
        check("rstmid_final", int'(bytes_sent), 1);
        uart_lat = 1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Drains the byte FIFO written by the AXI-Lite slave and sequences the UART transmitter one byte at a time.
- Owns the FIFO read port and the UART start/data handshake.
- Enforces CTS flow control and a programmable inter-byte idle gap.
- Keeps a saturating count of transmitted bytes.

Parameters:
GAP_WIDTH, 8, width of gap_cycles (inter-byte idle gap in clk cycles)
CNT_WIDTH, 16, width of bytes_sent counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  scheduler enable; sampled only in IDLE
gap_cycles  input  GAP_WIDTH  idle cycles inserted after each byte; sampled when leaving WAIT_DONE
cts_n  input  1  clear-to-send, active low; sampled only in IDLE
clr_count  input  1  synchronous clear of bytes_sent
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  one-cycle FIFO pop pulse
fifo_rd_data  input  8  FIFO read data; valid the cycle after fifo_rd_en
tx_busy  input  1  UART busy; rises after tx_start, falls when stop bit completes
tx_start  output  1  one-cycle UART launch pulse
tx_data  output  8  byte to transmit; registered, stable from LAUNCH until next LATCH
sched_active  output  1  high in every state except IDLE
bytes_sent  output  CNT_WIDTH  count of completed bytes, saturating

Behaviour:
- Reset: state IDLE; fifo_rd_en=0, tx_start=0, tx_data=0, sched_active=0, bytes_sent=0, gap counter=0.
- Moore FSM; fifo_rd_en, tx_start and sched_active are decoded from state only.
- States:
  - IDLE: go to FETCH when enable && !cts_n && !fifo_empty && !tx_busy; otherwise stay.
  - FETCH: fifo_rd_en=1 for exactly one cycle; go to LATCH.
  - LATCH: tx_data <= fifo_rd_data; go to LAUNCH.
  - LAUNCH: tx_start=1 for exactly one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: stay until tx_busy=0. On exit, increment bytes_sent. If gap_cycles==0 go to IDLE; else load the gap counter with gap_cycles and go to GAP.
  - GAP: decrement each cycle; go to IDLE on the cycle the counter is 1. GAP lasts exactly gap_cycles cycles.
- Latency: IDLE conditions true at cycle N -> fifo_rd_en at N+1, tx_data updated at N+3 (captured at end of N+2), tx_start at N+3.
- Minimum byte period: 5 + gap_cycles + UART busy time.
- Commitment: once FETCH is entered, the byte is always launched and completed. Deasserting enable or cts_n mid-byte only stops the next fetch. fifo_empty is ignored outside IDLE.
- Exactly one fifo_rd_en pulse per tx_start pulse; never two pops without an intervening launch.
- bytes_sent:
  - increments by 1 on WAIT_DONE exit;
  - saturates at all-ones (no wrap);
  - clr_count clears it to 0, and clear wins over a simultaneous increment.
- Changes to gap_cycles during GAP do not affect the running countdown.
- Reset mid-operation returns to IDLE immediately. An already-popped byte is discarded and not re-fetched. tx_start is never asserted in the cycle after reset.

Test Plan:
- Single byte: FIFO holds 0xA5, enable=1, cts_n=0, gap=0, UART busy 10 cycles -> one fifo_rd_en, tx_start 3 cycles after leaving IDLE with tx_data=0xA5, bytes_sent=1, sched_active returns low.
- Back-to-back with gaps: FIFO 0x11,0x22,0x33, gap_cycles=3 -> three tx_start pulses in order; exactly 3 GAP cycles between tx_busy fall and the next return to IDLE; bytes_sent=3; no fifo_rd_en after fifo_empty.
- Flow control: cts_n=1 with a non-empty FIFO -> no fifo_rd_en for 50 cycles. Drop cts_n -> transfer starts. Raise cts_n during WAIT_DONE -> current byte completes, next byte is not fetched.
- Enable drop mid-byte: enable=0 in LATCH -> tx_start still issued for the latched byte, bytes_sent increments, FSM then idles with data left in the FIFO.
- Counter edges (CNT_WIDTH=4): send 17 bytes -> bytes_sent=15. Assert clr_count on the WAIT_DONE exit cycle -> bytes_sent=0.
- Reset mid-operation: assert reset during WAIT_BUSY -> next cycle fifo_rd_en=0, tx_start=0, tx_data=0, bytes_sent=0, state IDLE. After release, the next FIFO byte is fetched, not the abandoned one.
